// File: rtl/debug_unit_dump_controller.sv
// Debug-unit dump controller: on a dump request, streams a header, the PC, the cycle count, the register file and the data memory over a byte-wide UART handshake.
// Build option: define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last memory byte.
module debug_unit_dump_controller #(
  parameter int unsigned N_BITS          = 8,
  parameter int unsigned N_BITS_WORD     = 32,
  parameter int unsigned N_BITS_REG      = 5,
  parameter int unsigned N_BITS_MEM_ADDR = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_dump_start,
  input  logic [N_BITS_WORD-1:0]     i_pc,
  input  logic [N_BITS_WORD-1:0]     i_cycle_count,
  output logic [N_BITS_REG-1:0]      o_reg_addr,
  input  logic [N_BITS_WORD-1:0]     i_reg_data,
  output logic [N_BITS_MEM_ADDR-1:0] o_mem_addr,
  input  logic [N_BITS_WORD-1:0]     i_mem_data,
  output logic                       o_tx_start,
  output logic [N_BITS-1:0]          o_tx_data,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_dump_done,
  output logic [3:0]                 o_state
);

  localparam int unsigned BYTES_PER_WORD = N_BITS_WORD / N_BITS;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HEADER    = 4'd1;
  localparam logic [3:0] S_PC        = 4'd2;
  localparam logic [3:0] S_CYCLES    = 4'd3;
  localparam logic [3:0] S_REG_FETCH = 4'd4;
  localparam logic [3:0] S_REG_SEND  = 4'd5;
  localparam logic [3:0] S_MEM_FETCH = 4'd6;
  localparam logic [3:0] S_MEM_SEND  = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [3:0] S_CHKSUM    = 4'd9;
`endif

  localparam logic [N_BITS-1:0]      HEADER_BYTE = N_BITS'(8'hA5);
  localparam logic [N_BITS_REG-1:0]  REG_LAST    = {N_BITS_REG{1'b1}};
  localparam logic [N_BITS_MEM_ADDR-1:0] MEM_LAST = {N_BITS_MEM_ADDR{1'b1}};

  logic [3:0]                 state_q, state_d;
  logic [N_BITS_WORD-1:0]     pc_q, pc_d;
  logic [N_BITS_WORD-1:0]     cyc_q, cyc_d;
  logic [N_BITS_WORD-1:0]     word_q, word_d;
  logic [CNT_W-1:0]           byte_cnt_q, byte_cnt_d;
  logic                       pending_q, pending_d;
  logic [N_BITS_REG-1:0]      reg_addr_q, reg_addr_d;
  logic [N_BITS_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic                       tx_start_q, tx_start_d;
  logic [N_BITS-1:0]          tx_data_q, tx_data_d;
  logic                       busy_q, busy_d;
  logic                       dump_done_q, dump_done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [N_BITS-1:0]          chk_q, chk_d;
`endif

  logic             send_state;
  logic [CNT_W-1:0] bytes_needed;
  logic             word_done;

  // Byte-sending states share one shift register; header and checksum are single-byte words.
`ifdef DUMP_CHECKSUM_EN
  assign send_state   = state_q inside {S_HEADER, S_PC, S_CYCLES, S_REG_SEND, S_MEM_SEND, S_CHKSUM};
  assign bytes_needed = (state_q == S_HEADER || state_q == S_CHKSUM) ? CNT_W'(1)
                                                                      : CNT_W'(BYTES_PER_WORD);
`else
  assign send_state   = state_q inside {S_HEADER, S_PC, S_CYCLES, S_REG_SEND, S_MEM_SEND};
  assign bytes_needed = (state_q == S_HEADER) ? CNT_W'(1) : CNT_W'(BYTES_PER_WORD);
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cyc_q       <= '0;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      pending_q   <= 1'b0;
      reg_addr_q  <= '0;
      mem_addr_q  <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      dump_done_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cyc_q       <= cyc_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      pending_q   <= pending_d;
      reg_addr_q  <= reg_addr_d;
      mem_addr_q  <= mem_addr_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      dump_done_q <= dump_done_d;
`ifdef DUMP_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cyc_d       = cyc_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    pending_d   = pending_q;
    reg_addr_d  = reg_addr_q;
    mem_addr_d  = mem_addr_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    dump_done_d = 1'b0;
    word_done   = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    // One byte in flight at a time; the next is launched only once the previous done has cleared pending.
    if (send_state) begin
      if (!pending_q) begin
        if (byte_cnt_q != bytes_needed) begin
          tx_start_d = 1'b1;
          tx_data_d  = word_q[N_BITS_WORD-1 -: N_BITS];
          word_d     = word_q << N_BITS;
          pending_d  = 1'b1;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
`ifdef DUMP_CHECKSUM_EN
          chk_d      = chk_q ^ word_q[N_BITS_WORD-1 -: N_BITS];
`endif
        end
      end else if (i_tx_done) begin
        pending_d = 1'b0;
        if (byte_cnt_q == bytes_needed) begin
          word_done  = 1'b1;
          byte_cnt_d = '0;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_dump_start) begin
          pc_d       = i_pc;
          cyc_d      = i_cycle_count;
          word_d     = {HEADER_BYTE, {(N_BITS_WORD-N_BITS){1'b0}}};
          byte_cnt_d = '0;
          pending_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_HEADER;
`ifdef DUMP_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      S_HEADER: begin
        if (word_done) begin
          word_d  = pc_q;
          state_d = S_PC;
        end
      end
      S_PC: begin
        if (word_done) begin
          word_d  = cyc_q;
          state_d = S_CYCLES;
        end
      end
      S_CYCLES: begin
        if (word_done) state_d = S_REG_FETCH;
      end
      S_REG_FETCH: begin
        word_d  = i_reg_data;
        state_d = S_REG_SEND;
      end
      S_REG_SEND: begin
        if (word_done) begin
          if (reg_addr_q == REG_LAST) begin
            state_d = S_MEM_FETCH;
          end else begin
            reg_addr_d = reg_addr_q + N_BITS_REG'(1);
            state_d    = S_REG_FETCH;
          end
        end
      end
      S_MEM_FETCH: begin
        word_d  = i_mem_data;
        state_d = S_MEM_SEND;
      end
      S_MEM_SEND: begin
        if (word_done) begin
          if (mem_addr_q == MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
            word_d  = {chk_q, {(N_BITS_WORD-N_BITS){1'b0}}};
            state_d = S_CHKSUM;
`else
            reg_addr_d  = '0;
            mem_addr_d  = '0;
            dump_done_d = 1'b1;
            state_d     = S_DONE;
`endif
          end else begin
            mem_addr_d = mem_addr_q + N_BITS_MEM_ADDR'(1);
            state_d    = S_MEM_FETCH;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CHKSUM: begin
        if (word_done) begin
          reg_addr_d  = '0;
          mem_addr_d  = '0;
          dump_done_d = 1'b1;
          state_d     = S_DONE;
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_reg_addr  = reg_addr_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_busy      = busy_q;
  assign o_dump_done = dump_done_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_debug_unit_dump_controller.sv
// Directed bench for debug_unit_dump_controller: UART byte-sink model, table of dump scenarios and expected frame bytes.
module tb_debug_unit_dump_controller;

`ifdef DUMP_CHECKSUM_EN
  localparam int FRAME_LEN = 202;
`else
  localparam int FRAME_LEN = 201;
`endif
  localparam int BUDGET = 8000;

  logic        i_clock;
  logic        i_reset;
  logic        i_dump_start;
  logic [31:0] i_pc;
  logic [31:0] i_cycle_count;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [3:0]  o_mem_addr;
  logic [31:0] i_mem_data;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_dump_done;
  logic [3:0]  o_state;

  debug_unit_dump_controller dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_dump_start  (i_dump_start),
    .i_pc          (i_pc),
    .i_cycle_count (i_cycle_count),
    .o_reg_addr    (o_reg_addr),
    .i_reg_data    (i_reg_data),
    .o_mem_addr    (o_mem_addr),
    .i_mem_data    (i_mem_data),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_done     (i_tx_done),
    .o_busy        (o_busy),
    .o_dump_done   (o_dump_done),
    .o_state       (o_state)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cyc;
    logic [31:0] rbase;
    logic [31:0] mbase;
    bit          zero;
    int          delay;
    bit          zlat;
    bit          spam;
  } dump_t;

  typedef struct {
    int         d;
    int         pos;
    logic [7:0] exp;
  } exp_t;

  dump_t      dumps[3];
  exp_t       exps[$];
  logic [7:0] frame[$];

  logic [31:0] rbase, mbase;
  bit          zero_w;
  int          tx_delay;
  bit          zlat;
  logic        spur;
  logic        tx_done_r;

  // Register file / memory read model: combinational lookup of the current address.
  assign i_reg_data = zero_w ? 32'h0 : rbase + 32'(o_reg_addr);
  assign i_mem_data = zero_w ? 32'h0 : mbase + 32'(o_mem_addr);
  assign i_tx_done  = tx_done_r | (zlat & o_tx_start) | spur;

  int         viol;
  int         cnt;
  bit         outstanding;
  bit         prev_start;
  logic [7:0] held;

  // UART sink: records bytes, returns done after tx_delay cycles, flags handshake violations.
  initial begin
    viol = 0; cnt = 0; outstanding = 0; prev_start = 0; held = '0; tx_done_r = 1'b0;
  end
  always @(negedge i_clock) begin
    tx_done_r = 1'b0;
    if (!i_reset) begin
      outstanding = 0;
      prev_start  = 0;
    end else begin
      if (o_tx_start && prev_start) viol++;
      if (o_tx_start && outstanding) viol++;
      if (outstanding && !o_tx_start && o_tx_data != held) viol++;
      if (outstanding) begin
        if (cnt <= 1) begin
          tx_done_r   = 1'b1;
          outstanding = 0;
        end else cnt--;
      end
      if (o_tx_start) begin
        frame.push_back(o_tx_data);
        held = o_tx_data;
        if (!zlat) begin
          outstanding = 1;
          cnt = tx_delay;
        end
      end
      prev_start = o_tx_start;
    end
  end

  int tests, fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"},  32'(o_tx_start),  32'h0);
    check({tag, "_tx_data"},   32'(o_tx_data),   32'h0);
    check({tag, "_busy"},      32'(o_busy),      32'h0);
    check({tag, "_dump_done"}, 32'(o_dump_done), 32'h0);
    check({tag, "_reg_addr"},  32'(o_reg_addr),  32'h0);
    check({tag, "_mem_addr"},  32'(o_mem_addr),  32'h0);
    check({tag, "_state"},     32'(o_state),     32'h0);
  endtask

  task automatic run_dump(input int id);
    int         n;
    bit         seen;
    int         dones;
    logic [7:0] act;
    rbase = dumps[id].rbase; mbase = dumps[id].mbase; zero_w = dumps[id].zero;
    tx_delay = dumps[id].delay; zlat = dumps[id].zlat;
    frame.delete();
    @(negedge i_clock);
    i_pc = dumps[id].pc; i_cycle_count = dumps[id].cyc; i_dump_start = 1'b1;
    @(negedge i_clock);
    i_dump_start = 1'b0; i_pc = '0; i_cycle_count = '0;
    check($sformatf("d%0d_start_busy", id), 32'(o_busy), 32'h1);
    check($sformatf("d%0d_start_state", id), 32'(o_state), 32'h1);
    n = 0; seen = 0; dones = 0;
    while (n < BUDGET && !seen) begin
      @(negedge i_clock);
      n++;
      i_dump_start = 1'b0;
      if (o_dump_done) begin
        seen = 1;
        dones++;
        check($sformatf("d%0d_done_state", id), 32'(o_state), 32'h8);
      end else if (dumps[id].spam && (n % 5 == 0)) i_dump_start = 1'b1;
    end
    i_dump_start = 1'b0;
    check($sformatf("d%0d_done_seen", id), 32'(seen), 32'h1);
    repeat (20) begin
      @(negedge i_clock);
      if (o_dump_done) dones++;
    end
    check($sformatf("d%0d_done_count", id), 32'(dones), 32'h1);
    check($sformatf("d%0d_idle_busy", id), 32'(o_busy), 32'h0);
    check($sformatf("d%0d_idle_state", id), 32'(o_state), 32'h0);
    check($sformatf("d%0d_idle_addr", id), 32'({o_reg_addr, o_mem_addr}), 32'h0);
    check($sformatf("d%0d_frame_len", id), 32'(frame.size()), 32'(FRAME_LEN));
    foreach (exps[i]) begin
      if (exps[i].d == id) begin
        act = (exps[i].pos < frame.size()) ? frame[exps[i].pos] : 8'hxx;
        check($sformatf("d%0d_byte%0d", id, exps[i].pos), {24'h0, act}, {24'h0, exps[i].exp});
      end
    end
  endtask

  initial begin
    int s0;
    int d;
    tests = 0; fails = 0;
    i_reset = 1'b0; i_dump_start = 1'b0; i_pc = '0; i_cycle_count = '0;
    rbase = '0; mbase = '0; zero_w = 0; tx_delay = 2; zlat = 0; spur = 1'b0;

    //            pc            cyc           rbase         mbase         zero delay zlat spam
    dumps[0] = '{32'h0000_0040, 32'h0000_0010, 32'h0000_0000, 32'h0000_00F0, 1'b0, 10, 1'b0, 1'b0};
    dumps[1] = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h0000_0100, 32'h1234_5600, 1'b0, 0,  1'b1, 1'b1};
    dumps[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1,  1'b0, 1'b0};

    exps.push_back('{0, 0,   8'hA5}); exps.push_back('{0, 1,   8'h00});
    exps.push_back('{0, 4,   8'h40}); exps.push_back('{0, 5,   8'h00});
    exps.push_back('{0, 8,   8'h10}); exps.push_back('{0, 12,  8'h00});
    exps.push_back('{0, 133, 8'h00}); exps.push_back('{0, 136, 8'h1F});
    exps.push_back('{0, 140, 8'hF0}); exps.push_back('{0, 197, 8'h00});
    exps.push_back('{0, 200, 8'hFF});
    exps.push_back('{1, 0,   8'hA5}); exps.push_back('{1, 1,   8'hDE});
    exps.push_back('{1, 2,   8'hAD}); exps.push_back('{1, 3,   8'hBE});
    exps.push_back('{1, 4,   8'hEF}); exps.push_back('{1, 5,   8'h01});
    exps.push_back('{1, 8,   8'h67}); exps.push_back('{1, 31,  8'h01});
    exps.push_back('{1, 32,  8'h05}); exps.push_back('{1, 135, 8'h01});
    exps.push_back('{1, 136, 8'h1F}); exps.push_back('{1, 197, 8'h12});
    exps.push_back('{1, 200, 8'h0F});
    exps.push_back('{2, 0,   8'hA5}); exps.push_back('{2, 4,   8'h00});
    exps.push_back('{2, 200, 8'h00});
`ifdef DUMP_CHECKSUM_EN
    exps.push_back('{2, 201, 8'hA5});
`endif

    repeat (3) @(negedge i_clock);
    check_all_zero("reset");
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);

    run_dump(0);
    run_dump(1);

    // Abort in HEADER with the header byte outstanding.
    tx_delay = 10; zlat = 0; zero_w = 0;
    @(negedge i_clock);
    i_pc = 32'h55; i_cycle_count = 32'h66; i_dump_start = 1'b1;
    @(negedge i_clock);
    i_dump_start = 1'b0;
    check("abort_hdr_state", 32'(o_state), 32'h1);
    repeat (3) @(negedge i_clock);
    check("abort_hdr_data", 32'(o_tx_data), 32'hA5);
    #1 i_reset = 1'b0;
    #1 check_all_zero("abort");
    d = 0;
    repeat (3) begin
      @(negedge i_clock);
      if (o_dump_done) d++;
    end
    check("abort_no_done", 32'(d), 32'h0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);

    run_dump(2);

    // Spurious tx_done while idle must not launch a byte.
    s0 = frame.size();
    spur = 1'b1;
    repeat (6) @(negedge i_clock);
    spur = 1'b0;
    repeat (4) @(negedge i_clock);
    check("spur_no_tx", 32'(frame.size()), 32'(s0));
    check("spur_state", 32'(o_state), 32'h0);

    check("tx_protocol", 32'(viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_unit_dump_controller.md
DEBUG_UNIT_DUMP_CONTROLLER -- requirements
Module: debug_unit_dump_controller

Interface
REQ-001 SHALL have parameter N_BITS, default 8, UART byte width.
REQ-002 SHALL have parameter N_BITS_WORD, default 32, width of PC, cycle count, register and memory words.
REQ-003 SHALL have parameter N_BITS_REG, default 5, register-file address width; 2**N_BITS_REG registers are dumped.
REQ-004 SHALL have parameter N_BITS_MEM_ADDR, default 4, data-memory address width; 2**N_BITS_MEM_ADDR words are dumped.
REQ-005 SHALL have port i_clock, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port i_dump_start, input, 1, single-cycle dump request (halt reached or step completed).
REQ-008 SHALL have ports i_pc and i_cycle_count, input, N_BITS_WORD each, values snapshotted at dump start.
REQ-009 SHALL have ports o_reg_addr, output, N_BITS_REG, and i_reg_data, input, N_BITS_WORD; read latency 1 cycle.
REQ-010 SHALL have ports o_mem_addr, output, N_BITS_MEM_ADDR, and i_mem_data, input, N_BITS_WORD; read latency 1 cycle.
REQ-011 SHALL have ports o_tx_start, output, 1; o_tx_data, output, N_BITS; i_tx_done, input, 1 (UART transmitter handshake).
REQ-012 SHALL have ports o_busy, output, 1; o_dump_done, output, 1 (single-cycle pulse); o_state, output, 4.

Function
REQ-013 SHALL implement states IDLE, HEADER, PC, CYCLES, REG_FETCH, REG_SEND, MEM_FETCH, MEM_SEND, DONE, encoded 0..8 in that order on o_state.
REQ-014 SHALL, when i_dump_start is high in IDLE at edge T, latch i_pc and i_cycle_count at T and enter HEADER at T+1 with o_busy=1.
REQ-015 SHALL ignore i_dump_start in any state other than IDLE.
REQ-016 SHALL send frame: 0xA5; PC; cycle count; registers 0..last; memory words 0..last; each word as N_BITS_WORD/N_BITS bytes, MSB first.
REQ-017 SHALL pulse o_tx_start for exactly one cycle per byte, holding o_tx_data stable from that cycle until i_tx_done is sampled high.
REQ-018 SHALL assert the next o_tx_start no earlier than the cycle after i_tx_done; i_tx_done with no byte outstanding SHALL be ignored.
REQ-019 SHALL, in REG_FETCH/MEM_FETCH, drive the address for one cycle, capture read data into the word shift register on the next edge, then enter the SEND state.
REQ-020 SHALL increment the address after the last byte of each word; at the final address, wrap-around SHALL NOT occur: REG_SEND goes to MEM_FETCH with o_mem_addr=0, and MEM_SEND goes to DONE.
REQ-021 SHALL, in DONE, pulse o_dump_done for one cycle, then return to IDLE with o_busy=0 on the following cycle.
REQ-022 SHALL hold o_reg_addr and o_mem_addr at 0 in IDLE.
REQ-023 SHALL, with default parameters and no checksum, send exactly 201 bytes per dump.

Reset
REQ-024 SHALL, on i_reset low, immediately force state IDLE and o_tx_start, o_tx_data, o_busy, o_dump_done, o_reg_addr, o_mem_addr, o_state, internal counters and snapshots to 0.
REQ-025 SHALL, on reset mid-dump, abort without o_dump_done; after release the next i_dump_start SHALL restart at the header byte.

Configuration
REQ-026 SHALL, with macro DUMP_CHECKSUM_EN defined, append one trailing byte equal to the XOR of all preceding frame bytes including 0xA5, sent before DONE (202 bytes default).
REQ-027 SHALL, without DUMP_CHECKSUM_EN, end the frame after the last memory byte and contain no checksum logic.

Verification
REQ-028 Reset low during HEADER -> all outputs 0, state IDLE; no o_dump_done.
REQ-029 i_pc=0x0000_0040, i_cycle_count=0x0000_0010, i_dump_start pulse, tx model done 10 cycles after start -> bytes A5 00 00 00 40 00 00 00 10 at bytes 1..9.
REQ-030 Register file r[n]=n, memory m[n]=0xF0+n -> 201 bytes; reg 31 bytes 00 00 00 1F; last bytes 00 00 00 FF; one o_dump_done.
REQ-031 i_dump_start repeated every 5 cycles during dump -> exactly one frame; spurious i_tx_done while idle -> no o_tx_start.
REQ-032 DUMP_CHECKSUM_EN defined, all words zero, pc=0 -> 202 bytes, final byte 0xA5.
REQ-033 i_tx_done returned in the same cycle as o_tx_start -> next o_tx_start no earlier than one cycle later; o_tx_data never changes while a byte is outstanding.
